uart_rx: RTL and testbench

- Serial UART receiver; sits directly downstream of the baud rate generator and consumes its oversample tick (rxClk) to recover frames from the rx pin.
- Frame format: 1 start bit (0), DataWidth data bits LSB first, optional parity bit, 1 stop bit (1).
- Delivers each received word to the bus-side register file over a valid/ready handshake.
- Flags framing and overrun errors.

---
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side word channel of uart_rx.
// Handshake: the master raises valid with data and holds both stable until a
// clk edge where valid && ready are both 1; that edge is the transfer. The
// slave may drive ready at any time, independent of valid.
interface uart_rx_if #(
  parameter int DataWidth = 8
);
  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, DataWidth data bits LSB first, optional parity
// bit, one stop bit. Timing is taken from the oversample strobe rxClk.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DataWidth  = 8,
  parameter int Oversample = 16,
  parameter int SyncStages = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxClk,
  input  logic       rx,
`ifdef UART_RX_PARITY_EN
  input  logic       parityOdd,
  output logic       parityError,
`endif
  uart_rx_if.master  bus,
  output logic       framingError,
  output logic       overrunError,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CntW = $clog2(Oversample);
  localparam int BitW = $clog2(DataWidth + 1);
  localparam logic [CntW-1:0] MidTick  = CntW'(Oversample / 2 - 1);
  localparam logic [CntW-1:0] LastTick = CntW'(Oversample - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DataWidth - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  state_t                 state;
  logic [SyncStages-1:0]  sync_q;
  logic                   rx_s;
  logic [CntW-1:0]        tick_cnt;
  logic [BitW-1:0]        bit_cnt;
  logic [DataWidth-1:0]   shift;
  logic                   pend;     // good stop seen last cycle: deliver now
`ifdef UART_RX_PARITY_EN
  logic                   par_bit;
`endif

  assign rx_s      = sync_q[SyncStages-1];
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Input synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SyncStages-2:0], rx};
  end

  // Frame FSM: everything advances only on rxClk strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      pend         <= 1'b0;
      framingError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      pend         <= 1'b0;
      framingError <= 1'b0;
      if (rxClk) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              tick_cnt <= '0;
              state    <= START;
            end
          end
          START: begin
            if (tick_cnt == MidTick) begin
              if (rx_s) begin
                state <= IDLE;          // glitch, not a real start bit
              end else begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                state    <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LastTick) begin
              shift <= {rx_s, shift[DataWidth-1:1]};
              if (bit_cnt == LastBit) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LastTick) begin
              par_bit <= rx_s;
              state   <= STOP;
            end
          end
`endif
          STOP: begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LastTick) begin
              if (rx_s) begin
                pend  <= 1'b1;
                state <= IDLE;          // leave at mid-stop to catch next start
              end else begin
                framingError <= 1'b1;
                state        <= BREAK;
              end
            end
          end
          BREAK: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Word delivery and overrun detection; a new load wins over a read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data     <= '0;
      bus.valid    <= 1'b0;
      overrunError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityError  <= 1'b0;
`endif
    end else begin
      overrunError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityError  <= 1'b0;
`endif
      if (pend) begin
        if (!bus.valid || bus.ready) begin
          bus.data  <= shift;
          bus.valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parityError <= (par_bit != (^shift ^ parityOdd));
`endif
        end else begin
          overrunError <= 1'b1;
        end
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for back-to-back, glitch, break, overrun, reset and parity cases.
module tb_uart_rx;

  localparam int Dw     = 8;
  localparam int Os     = 16;
  localparam int BitClk = Os * 4;   // rxClk strobes every 4 clk

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rxClk = 1'b0;
  logic       rx    = 1'b1;
  logic       fe, oe, busy;
  logic [2:0] st;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
  logic       pe;
  logic       bad_parity = 1'b0;
`endif

  uart_rx_if #(.DataWidth(Dw)) bus ();

  uart_rx #(.DataWidth(Dw), .Oversample(Os), .SyncStages(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rxClk        (rxClk),
    .rx           (rx),
`ifdef UART_RX_PARITY_EN
    .parityOdd    (parity_odd),
    .parityError  (pe),
`endif
    .bus          (bus),
    .framingError (fe),
    .overrunError (oe),
    .busy         (busy),
    .state_dbg    (st)
  );

  // Clock and oversample strobe
  always #5 clk = ~clk;

  initial begin : tick_gen
    int tick_div;
    tick_div = 0;
    forever begin
      @(negedge clk);
      rxClk    = (tick_div == 0);
      tick_div = (tick_div + 1) % 4;
    end
  end

  // Monitor: collects handshakes and error pulses
  logic [Dw-1:0] got_q[$];
  logic [Dw-1:0] exp_q[$];
  int fe_cnt = 0, oe_cnt = 0, pe_cnt = 0, overlap_cnt = 0, long_cnt = 0;
  logic fe_prev = 1'b0, oe_prev = 1'b0, pe_prev = 1'b0;

  always @(negedge clk) begin
    logic pe_now;
`ifdef UART_RX_PARITY_EN
    pe_now = pe;
`else
    pe_now = 1'b0;
`endif
    if (!reset) begin
      if (bus.valid && bus.ready) got_q.push_back(bus.data);
      if (fe) fe_cnt++;
      if (oe) oe_cnt++;
      if (pe_now) pe_cnt++;
      if ((fe && oe) || (fe && pe_now) || (oe && pe_now)) overlap_cnt++;
      if ((fe && fe_prev) || (oe && oe_prev) || (pe_now && pe_prev)) long_cnt++;
    end
    fe_prev = fe;
    oe_prev = oe;
    pe_prev = pe_now;
  end

  // Checking and driver tasks
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BitClk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [Dw-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < Dw; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ parity_odd ^ bad_parity);
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Compare handshakes from index base onward against the expected queue.
  task automatic expect_words(input string name, input int base);
    check({name, "_count"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) check({name, "_word"}, got_q[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  typedef struct {
    logic [Dw-1:0] d;
    logic          stop;
    int            exp_hs;
    int            exp_fe;
  } vec_t;

  vec_t vecs[8];

  initial begin : test
    int h0, f0, o0;
    vecs[0] = '{8'h55, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'hA3, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 1, 0};
    vecs[6] = '{8'h3C, 1'b0, 0, 1};
    vecs[7] = '{8'h00, 1'b0, 0, 1};

    bus.ready = 1'b1;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_valid", bus.valid, 0);
    check("rst_data", bus.data, 0);
    check("rst_busy", busy, 0);
    check("rst_state", st, 0);
    check("rst_fe", fe, 0);
    check("rst_oe", oe, 0);
    reset = 1'b0;
    idle(20);

    // Single frames from the table
    for (int i = 0; i < 8; i++) begin
      h0 = got_q.size(); f0 = fe_cnt; o0 = oe_cnt;
      send_frame(vecs[i].d, vecs[i].stop);
      check("busy_end_stop", busy, !vecs[i].stop);
      idle(2 * BitClk);
      check("busy_idle", busy, 0);
      check("hs_count", got_q.size() - h0, vecs[i].exp_hs);
      if (got_q.size() > h0) check("data", got_q[h0], vecs[i].d);
      check("fe_count", fe_cnt - f0, vecs[i].exp_fe);
      check("oe_count", oe_cnt - o0, 0);
    end

    // Back-to-back frames with no idle gap
    h0 = got_q.size();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle(2 * BitClk);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    expect_words("b2b", h0);

    // Short low glitch: no start bit
    h0 = got_q.size(); f0 = fe_cnt;
    rx = 1'b0;
    repeat (4 * 4) @(negedge clk);
    idle(2 * BitClk);
    check("glitch_hs", got_q.size() - h0, 0);
    check("glitch_state", st, 0);
    check("glitch_fe", fe_cnt - f0, 0);

    // Framing error with a long break, then a good frame
    h0 = got_q.size(); f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40 * 4) @(negedge clk);
    check("break_busy", busy, 1);
    check("break_fe", fe_cnt - f0, 1);
    check("break_valid", bus.valid, 0);
    idle(2 * BitClk);
    check("break_exit", busy, 0);
    send_frame(8'h81, 1'b1);
    idle(BitClk);
    exp_q.push_back(8'h81);
    expect_words("after_break", h0);

    // Overrun with ready held low
    @(posedge clk); #1 bus.ready = 1'b0;
    h0 = got_q.size(); o0 = oe_cnt;
    send_frame(8'h11, 1'b1);
    idle(BitClk);
    check("ovr_valid1", bus.valid, 1);
    check("ovr_data1", bus.data, 8'h11);
    check("ovr_oe0", oe_cnt - o0, 0);
    send_frame(8'h22, 1'b1);
    idle(BitClk);
    check("ovr_oe1", oe_cnt - o0, 1);
    check("ovr_data2", bus.data, 8'h11);
    check("ovr_valid2", bus.valid, 1);
    @(posedge clk); #1 bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_clr", bus.valid, 0);
    exp_q.push_back(8'h11);
    expect_words("ovr", h0);

    // Reset in the middle of the data bits
    h0 = got_q.size();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", st, 0);
    check("mid_rst_valid", bus.valid, 0);
    reset = 1'b0;
    idle(BitClk);
    send_frame(8'h99, 1'b1);
    idle(BitClk);
    exp_q.push_back(8'h99);
    expect_words("mid_rst", h0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit: word delivered, parity error flagged
    h0 = got_q.size(); f0 = pe_cnt;
    parity_odd = 1'b0;
    bad_parity = 1'b1;
    send_frame(8'h99, 1'b1);
    idle(BitClk);
    bad_parity = 1'b0;
    check("par_pe", pe_cnt - f0, 1);
    exp_q.push_back(8'h99);
    expect_words("par", h0);
    // Odd parity accepted when the bit matches
    h0 = got_q.size(); f0 = pe_cnt;
    parity_odd = 1'b1;
    send_frame(8'h5A, 1'b1);
    idle(BitClk);
    check("par_odd_pe", pe_cnt - f0, 0);
    exp_q.push_back(8'h5A);
    expect_words("par_odd", h0);
`endif

    check("pulse_overlap", overlap_cnt, 0);
    check("pulse_width", long_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
